uart_rx_gen: RTL

UART_RX_GEN -- requirements
Module: uart_rx_gen

---
 rtl/uart_pkg.sv | 20 ++
 rtl/uart_bit_sampler.sv | 47 ++++
 rtl/uart_rx_gen.sv | 154 +++++++++++++++
 3 files changed

// File: rtl/uart_pkg.sv
// Shared types, default parameter values and parity helper for the UART receiver.
package uart_pkg;

  localparam int DEF_DATA_BITS  = 8;
  localparam int DEF_OVERSAMPLE = 16;

  typedef enum logic [2:0] {
    IDLE   = 3'd0,
    START  = 3'd1,
    DATA   = 3'd2,
    PARITY = 3'd3,
    STOP   = 3'd4
  } rx_state_t;

  // Narrower payloads are zero-extended by the caller, which leaves the XOR unchanged.
  function automatic logic xor_reduce8(input logic [7:0] value);
    return ^value;
  endfunction

endpackage

// File: rtl/uart_bit_sampler.sv
// Per-bit tick counter and zero-vote counter; flags the last tick of a bit and its voted value.
module uart_bit_sampler
  import uart_pkg::*;
#(
  parameter int OVERSAMPLE = DEF_OVERSAMPLE
) (
  input  logic clk,
  input  logic rst,
  input  logic tick,
  input  logic run,
  input  logic rxd,
  output logic bit_done,
  output logic bit_val
);

  localparam int CW = $clog2(OVERSAMPLE) + 1;

  logic [CW-1:0] tick_cnt;
  logic [CW-1:0] zero_cnt;
  logic [CW-1:0] zero_sum;
  logic          last_tick;

  // Vote including the current sample, so the final tick of a bit counts too
  always_comb begin
    zero_sum  = zero_cnt + {{(CW-1){1'b0}}, ~rxd};
    last_tick = (tick_cnt == CW'(OVERSAMPLE - 1));
    bit_done  = tick & run & last_tick;
    bit_val   = (zero_sum > CW'(OVERSAMPLE / 2)) ? 1'b0 : 1'b1;
  end

  // Counters advance only on oversample ticks and restart at every bit boundary
  always_ff @(posedge clk) begin
    if (rst) begin
      tick_cnt <= '0;
      zero_cnt <= '0;
    end else if (tick && run) begin
      if (last_tick) begin
        tick_cnt <= '0;
        zero_cnt <= '0;
      end else begin
        tick_cnt <= tick_cnt + CW'(1);
        zero_cnt <= zero_sum;
      end
    end
  end

endmodule

// File: rtl/uart_rx_gen.sv
// Oversampling UART receiver: synchroniser, frame FSM, optional parity and sticky status flags.
module uart_rx_gen
  import uart_pkg::*;
#(
  parameter int DATA_BITS  = DEF_DATA_BITS,
  parameter int OVERSAMPLE = DEF_OVERSAMPLE,
  parameter int PARITY_EN  = 0,
  parameter int PARITY_ODD = 0
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 r_enable,
  input  logic                 rxd,
  input  logic                 rec_enable,
  output logic [DATA_BITS-1:0] data,
  output logic                 rda,
  output logic                 parity_err,
  output logic                 frame_err,
  output logic                 overrun
);

  localparam int IW        = $clog2(DATA_BITS) + 1;
  localparam bit USE_PAR   = (PARITY_EN != 0);
  localparam bit ODD_SENSE = (PARITY_ODD != 0);

  logic                 rxd_meta;
  logic                 rxd_sync;
  rx_state_t            state;
  rx_state_t            state_next;
  logic [IW-1:0]        bit_idx;
  logic [IW-1:0]        bit_idx_next;
  logic [DATA_BITS-1:0] shift;
  logic [DATA_BITS-1:0] shift_next;
  logic                 par_cand;
  logic                 par_cand_next;
  logic                 run;
  logic                 bit_done;
  logic                 bit_val;
  logic                 done;

  // Two-flop synchroniser for the asynchronous serial line
  always_ff @(posedge clk) begin
    if (rst) begin
      rxd_meta <= 1'b1;
      rxd_sync <= 1'b1;
    end else begin
      rxd_meta <= rxd;
      rxd_sync <= rxd_meta;
    end
  end

  // The idle tick that sees a low line is already the first tick of the start bit
  assign run = (state != IDLE) | ~rxd_sync;

  uart_bit_sampler #(
    .OVERSAMPLE(OVERSAMPLE)
  ) u_sampler (
    .clk      (clk),
    .rst      (rst),
    .tick     (r_enable),
    .run      (run),
    .rxd      (rxd_sync),
    .bit_done (bit_done),
    .bit_val  (bit_val)
  );

  // Frame sequencing: next state, shift register, bit index and parity candidate
  always_comb begin
    state_next    = state;
    bit_idx_next  = bit_idx;
    shift_next    = shift;
    par_cand_next = par_cand;
    done          = 1'b0;
    case (state)
      IDLE: begin
        if (r_enable && !rxd_sync) state_next = START;
        else                       state_next = IDLE;
      end
      START: begin
        if (bit_done) state_next = bit_val ? IDLE : DATA;
        else          state_next = START;
      end
      DATA: begin
        if (bit_done) begin
          shift_next = {bit_val, shift[DATA_BITS-1:1]};
          if (bit_idx == IW'(DATA_BITS - 1)) begin
            bit_idx_next = '0;
            state_next   = USE_PAR ? PARITY : STOP;
          end else begin
            bit_idx_next = bit_idx + IW'(1);
            state_next   = DATA;
          end
        end else begin
          state_next = DATA;
        end
      end
      PARITY: begin
        if (bit_done) begin
          par_cand_next = (xor_reduce8(8'(shift)) ^ bit_val) != ODD_SENSE;
          state_next    = STOP;
        end else begin
          state_next = PARITY;
        end
      end
      STOP: begin
        if (bit_done) begin
          done       = 1'b1;
          state_next = IDLE;
        end else begin
          state_next = STOP;
        end
      end
      default: state_next = IDLE;
    endcase
  end

  // Frame state registers move only on oversample ticks
  always_ff @(posedge clk) begin
    if (rst) begin
      state    <= IDLE;
      bit_idx  <= '0;
      shift    <= '0;
      par_cand <= 1'b0;
    end else if (r_enable) begin
      state    <= state_next;
      bit_idx  <= bit_idx_next;
      shift    <= shift_next;
      par_cand <= par_cand_next;
    end
  end

  // Completion outranks the consumer acknowledge arriving in the same cycle
  always_ff @(posedge clk) begin
    if (rst) begin
      data       <= '0;
      rda        <= 1'b0;
      parity_err <= 1'b0;
      frame_err  <= 1'b0;
      overrun    <= 1'b0;
    end else if (done) begin
      data       <= shift;
      rda        <= 1'b1;
      frame_err  <= ~bit_val;
      parity_err <= USE_PAR ? par_cand : 1'b0;
      overrun    <= rec_enable ? 1'b0 : (overrun | rda);
    end else if (rec_enable) begin
      rda        <= 1'b0;
      parity_err <= 1'b0;
      frame_err  <= 1'b0;
      overrun    <= 1'b0;
    end
  end

endmodule
